// File: rtl/soc_system_pcp_0_tc_mem_arb_pkg.sv
// Shared types and constants for the PCP tightly-coupled memory arbiter.
//   ADDR_W/DATA_W/DEPTH : memory geometry (6144 x 32, word addressed)
//   MAX_HOLD/ERR_W      : arbitration hold bound, error counter width
//   req_id_t            : requester id (REQ0 = PCP data master, REQ1 = DMA)
//   rd_tag_t            : in-flight read tag {pend, owner, oor}
package soc_system_pcp_0_tc_mem_arb_pkg;
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 6144;
  localparam int MAX_HOLD = 4;
  localparam int ERR_W    = 16;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    pend;
    req_id_t owner;
    logic    oor;
  } rd_tag_t;
endpackage

// File: rtl/soc_system_pcp_0_tc_mem_arb_grant.sv
// Round-robin grant with bounded hold for two requesters.
//   clk, rst_n   : clock, async active-low reset
//   active[1:0]  : requester has a command this cycle
//   grant_valid  : some requester is granted this cycle (combinational)
//   grant_id     : which one
// last_grant resets to REQ1 so REQ0 wins the first tie.
module soc_system_pcp_0_tc_mem_arb_grant
  import soc_system_pcp_0_tc_mem_arb_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] active,
  output logic       grant_valid,
  output req_id_t    grant_id
);
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD - 1);

  req_id_t           last_grant;
  logic [HOLD_W-1:0] hold_cnt;
  logic              prev_vld;   // a grant happened last cycle

  always_comb begin
    grant_valid = |active;
    grant_id    = REQ0;
    unique case (active)
      2'b01: grant_id = REQ0;
      2'b10: grant_id = REQ1;
      2'b11: begin
        // stay with the current owner only while it is streaming and under its hold bound
        if (prev_vld && (hold_cnt < HOLD_MAX)) grant_id = last_grant;
        else grant_id = (last_grant == REQ0) ? REQ1 : REQ0;
      end
      default: grant_id = REQ0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ1;
      hold_cnt   <= '0;
      prev_vld   <= 1'b0;
    end else begin
      prev_vld <= grant_valid;
      if (!grant_valid) begin
        hold_cnt <= '0;
      end else if (grant_id == last_grant) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        last_grant <= grant_id;
        hold_cnt   <= '0;
      end
    end
  end
endmodule

// File: rtl/soc_system_pcp_0_tc_mem_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one port of the PCP TCM.
//   clk, reset_n        : clock, async active-low reset
//   r0_* / r1_*         : Avalon-MM slave ports (PCP data master / DMA engine)
//   mem_*               : memory port drive; mem_readdata is valid 1 cycle after a read
//   err_count           : saturating count of out-of-range accesses
// Reads return with fixed latency 1 to the requester that issued them. Out-of-range
// commands are accepted but never reach the memory; such reads return zero.
module soc_system_pcp_0_tc_mem_arbiter #(
  parameter int ADDR_W   = soc_system_pcp_0_tc_mem_arb_pkg::ADDR_W,
  parameter int DATA_W   = soc_system_pcp_0_tc_mem_arb_pkg::DATA_W,
  parameter int DEPTH    = soc_system_pcp_0_tc_mem_arb_pkg::DEPTH,
  parameter int MAX_HOLD = soc_system_pcp_0_tc_mem_arb_pkg::MAX_HOLD,
  parameter int ERR_W    = soc_system_pcp_0_tc_mem_arb_pkg::ERR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   r0_address,
  input  logic [DATA_W/8-1:0] r0_byteenable,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W-1:0]   r0_writedata,
  output logic                r0_waitrequest,
  output logic [DATA_W-1:0]   r0_readdata,
  output logic                r0_readdatavalid,
  input  logic [ADDR_W-1:0]   r1_address,
  input  logic [DATA_W/8-1:0] r1_byteenable,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W-1:0]   r1_writedata,
  output logic                r1_waitrequest,
  output logic [DATA_W-1:0]   r1_readdata,
  output logic                r1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [ERR_W-1:0]    err_count
);
  import soc_system_pcp_0_tc_mem_arb_pkg::*;

  localparam int BE_W = DATA_W / 8;

  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][BE_W-1:0]   be;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0]             rd, wr, active, wait_o, rvld;
  logic [1:0][DATA_W-1:0] rdata;

  assign addr  = {r1_address, r0_address};
  assign be    = {r1_byteenable, r0_byteenable};
  assign wdata = {r1_writedata, r0_writedata};
  assign wr    = {r1_write, r0_write};
  // read+write together counts as a write
  assign rd    = {r1_read & ~r1_write, r0_read & ~r0_write};
  // nothing is granted while reset is held, which keeps the memory port quiet
  assign active = (rd | wr) & {2{reset_n}};

  logic    grant_valid;
  req_id_t grant_id;

  soc_system_pcp_0_tc_mem_arb_grant #(.HOLD(MAX_HOLD)) u_grant (
    .clk         (clk),
    .rst_n       (reset_n),
    .active      (active),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  logic [ADDR_W-1:0] sel_addr;
  logic              in_range;

  assign sel_addr = addr[grant_id];
  assign in_range = {1'b0, sel_addr} < (ADDR_W + 1)'(DEPTH);

  assign mem_address    = sel_addr;
  assign mem_byteenable = be[grant_id];
  assign mem_writedata  = wdata[grant_id];
  assign mem_write      = grant_valid & wr[grant_id];
  assign mem_chipselect = grant_valid & in_range;
  assign mem_clken      = 1'b1;

  // read tag: one slot suffices since latency is exactly one cycle
  rd_tag_t tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag <= '{pend: 1'b0, owner: REQ0, oor: 1'b0};
    end else begin
      tag.pend  <= grant_valid & rd[grant_id];
      tag.owner <= grant_id;
      tag.oor   <= ~in_range;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_count <= '0;
    else if (grant_valid && !in_range && (err_count != '1)) err_count <= err_count + 1'b1;
  end

  logic [DATA_W-1:0] rsp_data;
  assign rsp_data = tag.oor ? '0 : mem_readdata;

  for (genvar i = 0; i < 2; i++) begin : g_req
    localparam req_id_t ID = (i == 1) ? REQ1 : REQ0;
    logic [DATA_W-1:0] hold_q;   // last data delivered to this requester

    assign wait_o[i] = ~reset_n | (active[i] & ~(grant_valid & (grant_id == ID)));
    assign rvld[i]   = tag.pend & (tag.owner == ID);
    assign rdata[i]  = rvld[i] ? rsp_data : hold_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hold_q <= '0;
      else if (rvld[i]) hold_q <= rsp_data;
    end
  end

  assign r0_waitrequest   = wait_o[0];
  assign r1_waitrequest   = wait_o[1];
  assign r0_readdatavalid = rvld[0];
  assign r1_readdatavalid = rvld[1];
  assign r0_readdata      = rdata[0];
  assign r1_readdata      = rdata[1];
endmodule

// File: doc/soc_system_pcp_0_tc_mem_arbiter.md
Name: soc_system_pcp_0_tc_mem_arbiter

Overview:
- Shares one port of the PCP tightly-coupled memory (6144 x 32, bidirectional dual-port RAM) between two Avalon-MM requesters: req0 is the PCP data master and req1 is the DMA/packet-buffer engine.
- Arbitration is round-robin with a bounded hold, so streaming requesters stay efficient.
- Reads are tagged so each response returns to the requester that issued it.
- Out-of-range accesses are blocked, with reads returning zero, and each one is counted.

Parameters:
- ADDR_W, 13, word-address width of the memory and of both requester ports.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- DEPTH, 6144, number of implemented words. Addresses >= DEPTH are out of range.
- MAX_HOLD, 4, maximum consecutive grants to one requester while the other is waiting (>=1).
- ERR_W, 16, width of the error counter.

Ports:
- clk in 1: single clock for this block and the memory port.
- reset_n in 1: asynchronous, active-low reset.
- r0_address in ADDR_W; r0_byteenable in DATA_W/8; r0_read in 1; r0_write in 1; r0_writedata in DATA_W: requester 0 command.
- r0_waitrequest out 1; r0_readdata out DATA_W; r0_readdatavalid out 1: requester 0 response.
- r1_*: identical set for requester 1.
- mem_address out ADDR_W; mem_byteenable out DATA_W/8; mem_chipselect out 1; mem_write out 1; mem_writedata out DATA_W; mem_clken out 1: drive to the memory port.
- mem_readdata in DATA_W: memory read data, valid one cycle after the read command.
- err_count out ERR_W: saturating count of out-of-range accesses.

Behaviour:
- Reset values: r*_readdatavalid=0, r*_readdata=0, err_count=0, last_grant=1 (so req0 wins the first tie), hold_cnt=0.
- While reset_n is low: both waitrequests=1, mem_chipselect=0, mem_write=0.
- A requester is active when read|write is high. If read and write are both high, it is treated as a write.
- Grant is combinational in the same cycle. Exactly one active requester wins each cycle.
  - Only one active: it wins.
  - Both active, and winner-last-cycle == last_grant with hold_cnt < MAX_HOLD-1: last_grant wins again.
  - Otherwise: the non-last_grant requester wins.
- The winner sees waitrequest=0 in that cycle. The loser sees waitrequest=1 and must hold its command stable (Avalon rule).
- Idle requester's waitrequest=0 (Avalon pipelined convention).
- Hold counter:
  - Granting the same requester as last_grant increments hold_cnt, saturating at MAX_HOLD-1.
  - Switching sets last_grant and clears hold_cnt to 0.
  - An idle cycle (no grant) leaves last_grant unchanged and clears hold_cnt.
- Memory drive: mem_address, byteenable, writedata and write are taken from the winner (mux). mem_chipselect = grant_valid & in_range. mem_clken = 1 constantly.
- Out-of-range (address >= DEPTH):
  - mem_chipselect=0 and err_count++ (saturating at all-ones).
  - The command is still accepted: waitrequest follows normal arbitration.
  - An out-of-range read still produces readdatavalid, with readdata = 0.
- Read pipeline:
  - On a granted read, register rd_pend=1, rd_owner=winner, rd_oor=out-of-range.
  - Next cycle: r[rd_owner]_readdatavalid=1, r[rd_owner]_readdata = rd_oor ? 0 : mem_readdata.
  - Fixed read latency is 1. Throughput is one command per cycle.
- readdata for the non-owner holds its previous value. readdatavalid is a one-cycle pulse.
- Writes produce no response.
- Back-to-back: read followed by write to the same address returns the pre-write data. A write followed by a read returns the new data.
- Asynchronous reset mid-read drops the pending response; no readdatavalid is issued after release.

Decomposition:
- Package soc_system_pcp_0_tc_mem_arb_pkg holds:
  - the constants ADDR_W/DATA_W/DEPTH;
  - a requester-id typedef (1 bit, REQ0=0, REQ1=1);
  - a read-tag struct {pend, owner, oor}.
- Sub-module soc_system_pcp_0_tc_mem_arb_grant holds the round-robin/hold logic: inputs active[1:0]; outputs grant_valid and grant_id; it owns last_grant and hold_cnt.
- The top level holds the muxing, range check, read tag and error counter.

Test Plan:
- Reset release; r0 writes 0xA5A5_0001 to address 0x0010 (be=0xF), then reads 0x0010 -> r0_waitrequest=0 both cycles; r0_readdatavalid 1 cycle after the read, data 0xA5A5_0001; r1 sees no readdatavalid.
- Both requesters read continuously, MAX_HOLD=4, first cycle simultaneous -> grant sequence r0,r0,r0,r0,r1,r1,r1,r1,r0…; each readdatavalid goes to the correct owner with data from its own address.
- r1 writes 0x1234_5678 with be=0x3 over 0xFFFF_FFFF at address 0x17FF (last word) -> a later read returns 0xFFFF_5678.
- r0 reads address 0x1800 (=DEPTH), then writes 0x1FFF -> mem_chipselect=0 both cycles; r0_readdata=0 with readdatavalid; err_count=2; memory contents unchanged.
- r0 and r1 alternate single requests with idle gaps -> zero wait states, hold_cnt stays 0, no starvation; the first simultaneous request after reset goes to r0.
- Assert reset_n low in the cycle after a granted read -> no readdatavalid on either port; err_count=0; waitrequest=1 while in reset.
